mem_responder: RTL
==================

Name: mem_responder

Overview:
- Word-addressed unified instruction/data memory that answers the multicycle CPU's memory requests.
- It is the responder end of the CPU memory interface, driven by MemRead/MemWrite, the address and write data.
- Adds configurable wait states and a one-cycle ready handshake, so the controller can stall on slow memory instead of assuming single-cycle access.

Parameters:
- ADDR_W, 12, word-address width; depth = 2**ADDR_W words.
- DATA_W, 16, word width; matches the 16-bit instruction/data word.
- WAIT, 2, wait-state cycles between accept and response; legal range 0..15.
- INIT_FILE, "", hex file loaded into the array at elaboration; empty means no preload.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- mem_read  in  1  read request, level-sensitive.
- mem_write  in  1  write request, level-sensitive.
- addr  in  ADDR_W  word address.
- wdata  in  DATA_W  write data.
- rdata  out  DATA_W  read data, registered, held until the next read completes.
- ready  out  1  one-cycle pulse: the accepted access is complete.
- busy  out  1  high from the cycle after accept through the ready cycle.
- err  out  1  one-cycle pulse: illegal request (read and write both high) seen in IDLE.

Behaviour:
- Reset (rst low, asynchronous):
  - state=IDLE, wait counter=0, rdata=0, ready=0, busy=0, err=0.
  - Array contents are not cleared.
  - A pending, uncommitted write is discarded.
- States:
  - IDLE: accepts on a rising edge when exactly one of mem_read/mem_write is high. addr, wdata and op are latched; counter is loaded with WAIT; next state is WAIT_S if WAIT>0, else RESP.
  - IDLE with both mem_read and mem_write high: no access; err=1 for the next cycle; stays IDLE.
  - WAIT_S: counter decrements each edge. When counter==1, go to RESP.
  - RESP: ready=1 and busy=1 for exactly this one cycle, then go to IDLE.
- Commit point is the edge entering RESP:
  - Write: mem[latched addr] <= latched wdata.
  - Read: rdata <= mem[latched addr].
- Latency:
  - Accept edge t0; ready high in the cycle after edge t0+WAIT.
  - WAIT=0 gives ready in the cycle directly after accept.
- Handshake:
  - Request inputs are ignored outside IDLE.
  - addr/wdata changes after accept have no effect.
  - A request still high in the IDLE cycle after RESP is accepted as a new access. The requester must drop mem_read/mem_write during the ready cycle to avoid a repeat.
  - Minimum access period is WAIT+2 cycles.
- rdata changes only on read commit and on reset. Writes never disturb rdata.
- Read-after-write to the same address returns the new data.
- Address wrap: none needed; addr is exactly ADDR_W bits.
- Reset asserted during WAIT_S or RESP:
  - Immediate return to IDLE with all outputs 0.
  - An in-flight write is lost unless its commit edge already occurred.
- Storage is an inferred synchronous-write array, one port, one access per request.

Test Plan:
- Reset, then WAIT=2, write 0xBEEF to addr 0x010 → busy rises after the accept edge; ready pulses exactly 3 cycles after accept, for 1 cycle; rdata stays 0x0000.
- Read addr 0x010 after that write → ready 3 cycles after accept with rdata=0xBEEF; rdata holds 0xBEEF through later idle cycles.
- WAIT=0 build: read addr 0x000 preloaded with 0x1234 → ready and rdata=0x1234 in the cycle right after accept.
- mem_read=mem_write=1 in IDLE → err=1 for one cycle, busy=0, ready=0, memory unchanged (later read of that address returns the old value).
- Write 0x5555 to addr 0x020, change addr to 0x021 and toggle mem_read during WAIT_S → only 0x020 updated, no second access; 0x021 reads back unchanged.
- Write 0xAAAA to addr 0x030, pull rst low one cycle after accept → outputs 0 immediately, no ready; subsequent read of 0x030 returns its prior value.

Source files
------------

// File: rtl/mem_responder.sv
// Word-addressed unified instruction/data memory responder for the multicycle CPU.
// Adds WAIT wait-state cycles after accept, then a one-cycle ready pulse.
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-low reset
//   mem_read  read request (level)
//   mem_write write request (level)
//   addr      word address
//   wdata     write data
//   rdata     registered read data, held until the next read completes
//   ready     one-cycle pulse: accepted access complete
//   busy      high from the cycle after accept through the ready cycle
//   err       one-cycle pulse: read and write both requested while idle
module mem_responder #(
    parameter int    ADDR_W    = 12,
    parameter int    DATA_W    = 16,
    parameter int    WAIT      = 2,
    parameter string INIT_FILE = ""
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              mem_read,
    input  logic              mem_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    typedef enum logic [1:0] {
        IDLE,
        WAIT_S,
        RESP
    } state_t;

    localparam logic [3:0] WAIT_CNT = 4'(WAIT);

    logic [DATA_W-1:0] mem [2**ADDR_W];

    state_t            state;
    state_t            state_nx;
    logic [3:0]        cnt;
    logic [3:0]        cnt_nx;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              lat_we;

    logic              accept;
    logic              illegal;
    logic              commit;
    logic              c_we;
    logic [ADDR_W-1:0] c_addr;
    logic [DATA_W-1:0] c_wdata;

    assign accept  = (state == IDLE) && (mem_read ^ mem_write);
    assign illegal = (state == IDLE) && mem_read && mem_write;

    // With WAIT=0 the accept edge is also the commit edge, so the
    // commit must use the live request instead of the latched copy.
    assign c_we    = (state == IDLE) ? mem_write : lat_we;
    assign c_addr  = (state == IDLE) ? addr      : lat_addr;
    assign c_wdata = (state == IDLE) ? wdata     : lat_wdata;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        commit   = 1'b0;
        unique case (state)
            IDLE: begin
                if (accept) begin
                    cnt_nx = WAIT_CNT;
                    if (WAIT_CNT == 4'd0) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = WAIT_S;
                    end
                end
            end
            WAIT_S: begin
                if (cnt == 4'd1) begin
                    state_nx = RESP;
                    commit   = 1'b1;
                    cnt_nx   = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            RESP: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    // Gating with rst drops a write whose commit edge lands in reset.
    always_ff @(posedge clk) begin
        if (rst && commit && c_we) mem[c_addr] <= c_wdata;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            err       <= 1'b0;
            rdata     <= '0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_we    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            err   <= illegal;
            if (accept) begin
                lat_addr  <= addr;
                lat_wdata <= wdata;
                lat_we    <= mem_write;
            end
            if (commit && !c_we) rdata <= mem[c_addr];
        end
    end

    assign ready = (state == RESP);
    assign busy  = (state != IDLE);

endmodule
